// File: rtl/conv.sv
// Stand-alone 3x3 convolution core: walks every valid pixel of a fixed
// (r+c) mod 256 image, one multiply-accumulate per clock, and shows the last sum.
module conv #(
    parameter int H = 28,
    parameter int W = 28
) (
    input  logic               clk,
    input  logic               rst,
    output logic signed [31:0] result
);

    localparam int IW = $clog2(H);
    localparam int JW = $clog2(W);
    localparam logic [IW-1:0] ILAST = IW'(H - 3);
    localparam logic [JW-1:0] JLAST = JW'(W - 3);

    typedef enum logic [1:0] {MAC, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic [JW-1:0]      j_q, j_d;
    logic [3:0]         t_q, t_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] result_q, result_d;

    logic [1:0]         rowOff, colOff;
    logic signed [7:0]  weight;
    logic [7:0]         pixel;
    logic signed [31:0] product;

    // Tap t maps to kernel offset (t/3, t%3); weight k(a,b) = 3a+b+1 = t+1.
    always_comb begin
        rowOff = 2'd0;
        colOff = 2'd0;
        case (t_q)
            4'd1: begin rowOff = 2'd0; colOff = 2'd1; end
            4'd2: begin rowOff = 2'd0; colOff = 2'd2; end
            4'd3: begin rowOff = 2'd1; colOff = 2'd0; end
            4'd4: begin rowOff = 2'd1; colOff = 2'd1; end
            4'd5: begin rowOff = 2'd1; colOff = 2'd2; end
            4'd6: begin rowOff = 2'd2; colOff = 2'd0; end
            4'd7: begin rowOff = 2'd2; colOff = 2'd1; end
            4'd8: begin rowOff = 2'd2; colOff = 2'd2; end
            default: begin rowOff = 2'd0; colOff = 2'd0; end
        endcase
    end

    assign weight  = $signed({4'd0, t_q} + 8'd1);
    assign pixel   = 8'(i_q) + 8'(j_q) + {6'd0, rowOff} + {6'd0, colOff};
    assign product = $signed({24'd0, pixel}) * $signed({{24{weight[7]}}, weight});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MAC;
            i_q      <= '0;
            j_q      <= '0;
            t_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            t_q      <= t_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        t_d      = t_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            MAC: begin
                acc_d = acc_q + product;
                if (t_q == 4'd8) begin
                    state_d = WRITE;
                end else begin
                    t_d = t_q + 4'd1;
                end
            end
            WRITE: begin
                result_d = acc_q;
                acc_d    = '0;
                t_d      = '0;
                if (i_q == ILAST && j_q == JLAST) begin
                    state_d = DONE;
                end else begin
                    state_d = MAC;
                    if (j_q == JLAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = MAC;
            end
        endcase
    end

    assign result = result_q;

endmodule

// File: tb/tb_conv.sv
// Bench for conv: a 28x28 and a 3x5 instance share clock and reset and are
// compared every cycle against a direct evaluation of the convolution sum.
module tb_conv;

    logic               clk;
    logic               rst;
    logic signed [31:0] result;
    logic signed [31:0] result2;

    int testsRun;
    int testsFailed;
    int edges;
    bit checkEn;

    conv #(.H(28), .W(28)) dut (
        .clk    (clk),
        .rst    (rst),
        .result (result)
    );

    conv #(.H(3), .W(5)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .result (result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release; edge 1 is the first one.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Straight evaluation of the sum of k(a,b)*p(i+a,j+b) with 32-bit wrap.
    function automatic int outVal(input int i, input int j);
        int sum;
        sum = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                sum += (3 * a + b + 1) * ((i + a + j + b) % 256);
        return sum;
    endfunction

    // Value result must show after edge e: pixel n lands on edge 10(n+1), last one holds.
    function automatic int expectedAt(input int e, input int h, input int w);
        int n;
        int total;
        total = (h - 2) * (w - 2);
        if (e < 10) return 0;
        n = e / 10 - 1;
        if (n > total - 1) n = total - 1;
        return outVal(n / (w - 2), n % (w - 2));
    endfunction

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input int required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, required, edges);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model28x28", result, expectedAt(edges, 28, 28));
            checkOutput("model3x5", result2, expectedAt(edges, 3, 5));
        end
    end

    task automatic applyStimulus(input int holdCycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (holdCycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runTo(input int target);
        int guard;
        guard = 0;
        while (edges < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (edges < target) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL runTo: reached edge %0d, expected %0d", edges, target);
        end
    endtask

    initial begin
        int midCycle;
        int offset;
        testsRun    = 0;
        testsFailed = 0;
        checkEn     = 1'b0;
        rst         = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetHold", result, 0);
        checkOutput("resetHold3x5", result2, 0);
        checkEn = 1'b1;
        rst     = 1'b0;

        runTo(9);
        checkOutput("edge9", result, 0);
        runTo(10);
        checkOutput("out00", result, 114);
        runTo(20);
        checkOutput("out01", result, 159);
        checkOutput("sweep20", result2, 159);
        runTo(30);
        checkOutput("sweep30", result2, 204);
        runTo(260);
        checkOutput("out0_25", result, 1239);
        runTo(270);
        checkOutput("out1_0", result, 159);
        runTo(6760);
        checkOutput("outLast", result, 2364);
        runTo(7760);
        checkOutput("doneHold", result, 2364);
        checkOutput("sweepHold", result2, 204);

        applyStimulus(2);
        runTo(10);
        checkOutput("restart", result, 114);

        midCycle = 2990 + int'($urandom_range(20));
        offset   = 1 + int'($urandom_range(2));
        runTo(midCycle);
        @(posedge clk);
        #(offset);
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", result, 0);
        checkOutput("asyncReset3x5", result2, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        runTo(9);
        checkOutput("postReset9", result, 0);
        runTo(10);
        checkOutput("postReset10", result, 114);
        runTo(40);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/conv.md
Name: conv

Overview:
- Self-contained 2-D convolution engine with an internal H×W 8-bit image ROM and a fixed 3×3 signed kernel.
- Computes every "valid" output pixel, (H-2)×(W-2) of them, sequentially with one multiply-accumulate per clock.
- Presents the most recently completed output pixel on `result`.
- Used as a stand-alone compute core for FPGA bring-up; it has no data inputs.

Parameters:
- H, 28, image height in pixels (≥3).
- W, 28, image width in pixels (≥3).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- result  output  32  signed two's-complement value of the most recently completed output pixel.

Behaviour:
- Reset:
  - While rst=1: result=0, state=MAC, row i=0, col j=0, tap t=0, acc=0.
  - Reset is asynchronous: asserting it at any time aborts the current pass immediately.
  - Computation restarts from (0,0) on the first rising edge after release.
- Image ROM:
  - p(r,c) = (r+c) mod 256, unsigned 8-bit, for r in 0..H-1 and c in 0..W-1.
  - Implement as a ROM or combinational function; content is fixed.
- Kernel:
  - k(a,b) = 3a+b+1 for a,b in 0..2, i.e. rows [1 2 3; 4 5 6; 7 8 9].
  - Stored as signed 8-bit constants.
- Output definition:
  - out(i,j) = Σ k(a,b)·p(i+a, j+b) over a,b in 0..2.
  - i in 0..H-3, j in 0..W-3.
- Arithmetic:
  - Pixel is zero-extended, weight sign-extended, product signed.
  - Accumulator is 32-bit signed and wraps modulo 2^32; no saturation.
- Scan order: row-major, j innermost. Tap order t=0..8 with a=t/3, b=t%3.
- FSM states: MAC, WRITE, DONE.
  - MAC: each edge does acc += k(a,b)·p(i+a, j+b) and t++. On the edge with t=8, go to WRITE.
  - WRITE (one cycle): result <= acc, acc <= 0, t <= 0, advance (i,j).
    - If (i,j) was the last position (H-3, W-3), go to DONE.
    - Otherwise return to MAC.
  - DONE: idle; result holds the final value indefinitely; no further updates until reset.
- Timing:
  - 10 cycles per output pixel (9 MAC + 1 WRITE).
  - Output n (0-based, n = i·(W-2)+j) appears on result after rising edge 10·(n+1), counting the first edge after reset release as edge 1.
  - Full pass is 10·(H-2)·(W-2) cycles; 6760 cycles for 28×28, which is 270.4 µs at a 40 ns clock.
- Closed-form result with default kernel and image, no wrap: out(i,j) = 45·(i+j) + 114.
- result changes only on WRITE edges or reset; it is stable between them.
- Edge cases:
  - H=3 or W=3 gives a single-column or single-row output.
  - If reset is asserted during WRITE, the reset value wins.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then check result=0. Release; after edges 1–9, result is still 0. After edge 10, result=114, i.e. out(0,0).
- Sequence: capture result after each WRITE. Values must be 114, 159, 204, … (step +45 along a row). out(0,25)=1239, out(1,0)=159, out(25,25)=2364.
- Completion: after edge 6760, result=2364. It must remain 2364 for at least 1000 further cycles (DONE holds).
- Mid-run reset: assert rst asynchronously (not edge-aligned) around cycle 3000. result must go to 0 immediately. After release, the first WRITE gives 114 again after 10 edges.
- Parameter sweep: H=3, W=5 gives outputs 114, 159, 204 at edges 10, 20, 30, then holds 204.
- Timing check: result changes only on edges that are multiples of 10 after release. It has no glitches or changes between those edges.
